i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h44, is the 7-bit address this target answers to.
REQ-002 Parameter FILTER_LEN, default 4, is the number of consecutive identical clk samples required before a filtered SCL/SDA level changes.
REQ-003 Parameter HOLD_CYCLES, default 240, is the number of clk cycles after a filtered SCL falling edge before sda_drive_low may change.
REQ-004 Port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port scl_in, input, 1: raw bus SCL level, asynchronous to clk.
REQ-007 Port sda_in, input, 1: raw bus SDA level, asynchronous to clk.
REQ-008 Port sda_drive_low, output, 1: 1 = pull SDA low, 0 = release SDA.
REQ-009 Port rx_data, output, 8: last byte written by the controller, MSB first on the bus.
REQ-010 Port rx_valid, output, 1: one-cycle pulse when rx_data is updated.
REQ-011 Port tx_data, input, 8: byte to return on a read.
REQ-012 Port tx_req, output, 1: one-cycle pulse requesting that the next tx_data be presented.
REQ-013 Port start_det, output, 1: one-cycle pulse on START or repeated START.
REQ-014 Port stop_det, output, 1: one-cycle pulse on STOP.
REQ-015 Port addressed, output, 1: high from address ACK until the next START or STOP.
REQ-016 Port nack_rcvd, output, 1: one-cycle pulse when the controller NACKs a read byte.

Function
REQ-017 SCL and SDA shall each pass through a 2-FF synchronizer and then the FILTER_LEN glitch filter; every rule below uses the filtered levels.
REQ-018 Edges shall be detected as filtered-level transitions; each edge is reported once.
REQ-019 START = SDA falling while SCL high; STOP = SDA rising while SCL high; either is honoured in every state and overrides any same-cycle bit processing.
REQ-020 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-021 START -> ADDR with the bit counter cleared and sda_drive_low 0; STOP -> IDLE; start_det/stop_det pulse in the cycle the condition is detected.
REQ-022 ADDR: shift SDA on 8 SCL rising edges, MSB first; bits 7:1 = address, bit 0 = R/W.
REQ-023 On the 8th bit: address match -> ADDR_ACK; mismatch -> WAIT_STOP with SDA released; WAIT_STOP ignores everything except START and STOP.
REQ-024 ACK driving: HOLD_CYCLES after the SCL falling edge that ends bit 8, assert sda_drive_low; release it HOLD_CYCLES after the next SCL falling edge.
REQ-025 ADDR_ACK: set addressed when the ACK is asserted; R/W=0 -> WRITE; R/W=1 -> pulse tx_req at the ACK assert, latch tx_data at ACK release, go to READ.
REQ-026 WRITE: shift 8 bits on SCL rising edges; on the 8th, update rx_data, pulse rx_valid, go to WRITE_ACK (ACK per REQ-024), then back to WRITE.
REQ-027 READ: drive the latched byte MSB first; each bit changes HOLD_CYCLES after an SCL falling edge; 1 = release, 0 = pull low; after 8 bits release SDA and go to READ_ACK.
REQ-028 READ_ACK: sample SDA on the SCL rising edge.
REQ-029 READ_ACK, SDA low: pulse tx_req on that rising edge, latch tx_data on the following falling edge, return to READ.
REQ-030 READ_ACK, SDA high: pulse nack_rcvd and go to WAIT_STOP.
REQ-031 The bit counter is 4 bits and clears on every state entry; it never wraps within a byte.
REQ-032 sda_drive_low shall never change while filtered SCL is high, except when START or STOP forces a release.
REQ-033 A repeated START mid-byte aborts the byte: no rx_valid and no ACK.

Reset
REQ-034 rst_n low immediately forces IDLE and clears sda_drive_low, rx_data, rx_valid, tx_req, start_det, stop_det, addressed, nack_rcvd, the counters and shift registers; the filters reset to level 1.
REQ-035 After reset release the block ignores the bus until a STOP is seen or both filtered lines have been high for FILTER_LEN cycles.

Verification
REQ-036 Write 0x88 (addr 0x44, W) then 0xFD -> ACK on both bytes; rx_data=0xFD; exactly one rx_valid pulse.
REQ-037 Read 0x89 with tx_data=0xA5, then 0x3C, controller ACK then NACK -> bus carries A5 then 3C; two tx_req pulses; one nack_rcvd pulse.
REQ-038 Address 0x45 -> no ACK; sda_drive_low stays 0; addressed stays 0 through STOP.
REQ-039 Write, then repeated START with a read and no STOP -> start_det pulses twice; direction switches cleanly.
REQ-040 3-cycle SDA glitch while SCL is high -> no START or STOP detected.
REQ-041 rst_n pulsed low while READ drives a 0 -> sda_drive_low goes to 0 asynchronously; state is IDLE.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: 7-bit-addressed I2C target with synchronised, glitch-filtered
// SCL/SDA inputs. Write bytes appear on rx_data/rx_valid. Read bytes are taken
// from tx_data after a tx_req pulse. SDA changes only a fixed hold time after
// each filtered SCL falling edge.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h44,
    parameter int         FILTER_LEN  = 4,
    parameter int         HOLD_CYCLES = 240
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       start_det,
    output logic       stop_det,
    output logic       addressed,
    output logic       nack_rcvd
);

    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FILT_MAX  = FCNT_W'(FILTER_LEN - 1);
    localparam logic [HCNT_W-1:0] HOLD_LOAD = HCNT_W'(HOLD_CYCLES);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK = 3'd4;
    localparam logic [2:0] ST_READ      = 3'd5;
    localparam logic [2:0] ST_READ_ACK  = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    logic              scl_sync_p0, scl_sync_p1;
    logic              sda_sync_p0, sda_sync_p1;
    logic              scl_f, sda_f;
    logic [FCNT_W-1:0] scl_fcnt, sda_fcnt;
    logic              scl_d, sda_d;
    logic              armed;
    logic [FCNT_W-1:0] arm_cnt;
    logic [HCNT_W-1:0] hold_cnt;
    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic              rw;

    logic scl_rise, scl_fall, start_raw, stop_raw, start_cond, stop_cond, hold_fire;

    assign scl_rise   = scl_f & ~scl_d;
    assign scl_fall   = ~scl_f & scl_d;
    assign start_raw  = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_raw   = scl_f & scl_d & ~sda_d & sda_f;
    assign start_cond = armed & start_raw;
    assign stop_cond  = armed & stop_raw;
    // The hold delay only acts while SCL is low, so SDA never moves under a high SCL.
    assign hold_fire  = (hold_cnt == HCNT_W'(1)) && !scl_f;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_p0 <= 1'b1;
            scl_sync_p1 <= 1'b1;
            sda_sync_p0 <= 1'b1;
            sda_sync_p1 <= 1'b1;
        end else begin
            scl_sync_p0 <= scl_in;
            scl_sync_p1 <= scl_sync_p0;
            sda_sync_p0 <= sda_in;
            sda_sync_p1 <= sda_sync_p0;
        end
    end

    // SCL glitch filter: level follows only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_f    <= 1'b1;
            scl_fcnt <= '0;
        end else if (scl_sync_p1 == scl_f) begin
            scl_fcnt <= '0;
        end else if (scl_fcnt == FILT_MAX) begin
            scl_f    <= scl_sync_p1;
            scl_fcnt <= '0;
        end else begin
            scl_fcnt <= scl_fcnt + FCNT_W'(1);
        end
    end

    // SDA glitch filter, same rule as SCL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_f    <= 1'b1;
            sda_fcnt <= '0;
        end else if (sda_sync_p1 == sda_f) begin
            sda_fcnt <= '0;
        end else if (sda_fcnt == FILT_MAX) begin
            sda_f    <= sda_sync_p1;
            sda_fcnt <= '0;
        end else begin
            sda_fcnt <= sda_fcnt + FCNT_W'(1);
        end
    end

    // Previous filtered levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    // Stay deaf after reset until a STOP or a stretch of idle-high bus is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            arm_cnt <= '0;
        end else if (!armed) begin
            if (stop_raw) begin
                armed <= 1'b1;
            end else if (scl_f && sda_f) begin
                if (arm_cnt == FILT_MAX) armed <= 1'b1;
                else                     arm_cnt <= arm_cnt + FCNT_W'(1);
            end else begin
                arm_cnt <= '0;
            end
        end
    end

    // Hold timer restarted by every SCL falling edge; fires HOLD_CYCLES later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (start_cond || stop_cond) begin
            hold_cnt <= '0;
        end else if (scl_fall) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HCNT_W'(1);
        end
    end

    // Protocol state machine; START/STOP take priority over any bit activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            rw            <= 1'b0;
            sda_drive_low <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            tx_req        <= 1'b0;
            start_det     <= 1'b0;
            stop_det      <= 1'b0;
            addressed     <= 1'b0;
            nack_rcvd     <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            nack_rcvd <= 1'b0;
            if (start_cond) begin
                start_det     <= 1'b1;
                state         <= ST_ADDR;
                bit_cnt       <= '0;
                sda_drive_low <= 1'b0;
                addressed     <= 1'b0;
            end else if (stop_cond) begin
                stop_det      <= 1'b1;
                state         <= ST_IDLE;
                bit_cnt       <= '0;
                sda_drive_low <= 1'b0;
                addressed     <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_f};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                rw      <= sda_f;
                                // shift[6:0] already holds address bits 7:1 here
                                if (shift[6:0] == TARGET_ADDR) state <= ST_ADDR_ACK;
                                else                           state <= ST_WAIT_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // bit_cnt 0: waiting to assert ACK, 1: waiting to release it
                        if (hold_fire) begin
                            if (bit_cnt == 4'd0) begin
                                sda_drive_low <= 1'b1;
                                addressed     <= 1'b1;
                                tx_req        <= rw;
                                bit_cnt       <= 4'd1;
                            end else begin
                                bit_cnt <= '0;
                                if (rw) begin
                                    shift         <= tx_data;
                                    sda_drive_low <= ~tx_data[7];
                                    state         <= ST_READ;
                                end else begin
                                    sda_drive_low <= 1'b0;
                                    state         <= ST_WRITE;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda_f};
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {shift[6:0], sda_f};
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                                state    <= ST_WRITE_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (hold_fire) begin
                            if (bit_cnt == 4'd0) begin
                                sda_drive_low <= 1'b1;
                                bit_cnt       <= 4'd1;
                            end else begin
                                sda_drive_low <= 1'b0;
                                bit_cnt       <= '0;
                                state         <= ST_WRITE;
                            end
                        end
                    end
                    ST_READ: begin
                        // MSB is already on the bus on entry; each fire moves to the next bit
                        if (hold_fire) begin
                            if (bit_cnt == 4'd7) begin
                                sda_drive_low <= 1'b0;
                                bit_cnt       <= '0;
                                state         <= ST_READ_ACK;
                            end else begin
                                sda_drive_low <= ~shift[6];
                                shift         <= {shift[6:0], 1'b0};
                                bit_cnt       <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        // bit_cnt 0: sample ACK, 1: latch next byte, 2: drive its MSB
                        if (scl_rise && bit_cnt == 4'd0) begin
                            if (!sda_f) begin
                                tx_req  <= 1'b1;
                                bit_cnt <= 4'd1;
                            end else begin
                                nack_rcvd <= 1'b1;
                                state     <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            shift   <= tx_data;
                            bit_cnt <= 4'd2;
                        end else if (hold_fire && bit_cnt == 4'd2) begin
                            sda_drive_low <= ~shift[7];
                            bit_cnt       <= '0;
                            state         <= ST_READ;
                        end
                    end
                    default: begin
                        // IDLE and WAIT_STOP only react to START/STOP
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus controller model drives SCL/SDA, a wired-AND
// bus combines it with the target, and a queue-based model predicts the
// bytes, acknowledges and pulse counts the target must produce.
`timescale 1ns/1ps
module tb_i2c_target;
    localparam logic [6:0] ADDR = 7'h44;
    localparam int FLEN = 4;
    localparam int HOLD = 12;

    logic       clk = 1'b0;
    logic       rst_n, ctrl_scl, ctrl_sda, sda_bus;
    logic       sda_drive_low, rx_valid, tx_req, start_det, stop_det, addressed, nack_rcvd;
    logic [7:0] rx_data, tx_data;

    assign sda_bus = ctrl_sda & ~sda_drive_low;

    i2c_target #(.TARGET_ADDR(ADDR), .FILTER_LEN(FLEN), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(ctrl_scl), .sda_in(sda_bus),
        .sda_drive_low(sda_drive_low), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_req(tx_req), .start_det(start_det),
        .stop_det(stop_det), .addressed(addressed), .nack_rcvd(nack_rcvd));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cnt_start = 0, cnt_stop = 0, cnt_rxv = 0, cnt_txreq = 0, cnt_nack = 0;
    int e_start = 0, e_stop = 0, e_rxv = 0, e_txreq = 0, e_nack = 0;
    logic quiet_chk = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] tx_plan[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        chk("cnt_start", cnt_start, e_start);
        chk("cnt_stop", cnt_stop, e_stop);
        chk("cnt_rx_valid", cnt_rxv, e_rxv);
        chk("cnt_tx_req", cnt_txreq, e_txreq);
        chk("cnt_nack", cnt_nack, e_nack);
    endtask

    // Per-cycle compare against the model: SDA timing, quiet target, rx bytes, pulses.
    initial begin
        logic prev_drive, p_rxv, p_txr, p_sta, p_sto, p_nak;
        int scl_low_cnt;
        prev_drive = 1'b0; p_rxv = 0; p_txr = 0; p_sta = 0; p_sto = 0; p_nak = 0;
        scl_low_cnt = 0;
        forever begin
            @(negedge clk);
            if (ctrl_scl) scl_low_cnt = 0;
            else          scl_low_cnt++;
            if (rst_n) begin
                if (sda_drive_low !== prev_drive && !start_det && !stop_det) begin
                    chk("drive_change_scl_low", int'(ctrl_scl), 0);
                    chk("drive_change_hold", (scl_low_cnt >= HOLD) ? 1 : 0, 1);
                end
                if (quiet_chk) begin
                    chk("quiet_drive", int'(sda_drive_low), 0);
                    chk("quiet_addressed", int'(addressed), 0);
                end
                if (rx_valid) begin
                    cnt_rxv++;
                    chk("rx_valid_width", int'(p_rxv), 0);
                    if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
                    else chk("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
                end
                if (tx_req) begin cnt_txreq++; chk("tx_req_width", int'(p_txr), 0); end
                if (start_det) begin cnt_start++; chk("start_width", int'(p_sta), 0); end
                if (stop_det) begin cnt_stop++; chk("stop_width", int'(p_sto), 0); end
                if (nack_rcvd) begin cnt_nack++; chk("nack_width", int'(p_nak), 0); end
            end
            prev_drive = sda_drive_low;
            p_rxv = rx_valid; p_txr = tx_req; p_sta = start_det; p_sto = stop_det; p_nak = nack_rcvd;
        end
    end

    // Byte source: answers each tx_req with the next planned or a random byte.
    initial begin
        tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && tx_req) begin
                if (tx_plan.size() != 0) tx_data = tx_plan.pop_front();
                else                     tx_data = 8'($urandom);
                exp_tx.push_back(tx_data);
            end
        end
    end

    // One SCL clock with SCL entering and leaving low; returns the bus SDA at mid-high.
    task automatic clock_bit(input logic b, output logic s);
        wait_clks(10);
        ctrl_sda = b;
        wait_clks(30);
        ctrl_scl = 1'b1;
        wait_clks(20);
        s = sda_bus;
        wait_clks(20);
        ctrl_scl = 1'b0;
    endtask

    task automatic do_start();
        if (ctrl_scl == 1'b0) begin
            wait_clks(10);
            ctrl_sda = 1'b1;
            wait_clks(30);
            ctrl_scl = 1'b1;
            wait_clks(40);
        end
        ctrl_sda = 1'b0;
        wait_clks(40);
        ctrl_scl = 1'b0;
    endtask

    task automatic do_stop();
        wait_clks(10);
        ctrl_sda = 1'b0;
        wait_clks(30);
        ctrl_scl = 1'b1;
        wait_clks(40);
        ctrl_sda = 1'b1;
        wait_clks(40);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(b[i], s);
            chk("wr_bit_echo", int'(s), int'(b[i]));
        end
        clock_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(~ack, s);
    endtask

    task automatic run_txn(input logic [6:0] a, input logic rw, input int n, input logic with_stop);
        logic acked;
        logic [7:0] d, b;
        logic match;
        match = (a == ADDR);
        do_start();
        e_start++;
        quiet_chk = !match;
        write_byte({a, rw}, acked);
        chk("addr_ack", int'(acked), int'(match));
        chk("addressed", int'(addressed), int'(match));
        if (match) begin
            for (int i = 0; i < n; i++) begin
                if (!rw) begin
                    b = 8'($urandom);
                    exp_rx.push_back(b);
                    e_rxv++;
                    write_byte(b, acked);
                    chk("data_ack", int'(acked), 1);
                end else begin
                    read_byte(i != n - 1, d);
                    e_txreq++;
                    if (exp_tx.size() == 0) chk("rd_missing", 1, 0);
                    else chk("rd_data", int'(d), int'(exp_tx.pop_front()));
                end
            end
            if (rw) e_nack++;
        end
        if (with_stop) begin
            do_stop();
            e_stop++;
            chk("addressed_after_stop", int'(addressed), 0);
        end
        quiet_chk = 1'b0;
        check_counts();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acked, s;
        logic [7:0] d;
        int s0;
        rst_n = 1'b0; ctrl_scl = 1'b1; ctrl_sda = 1'b1;
        wait_clks(5);
        chk("rst_drive", int'(sda_drive_low), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_tx_req", int'(tx_req), 0);
        chk("rst_start", int'(start_det), 0);
        chk("rst_stop", int'(stop_det), 0);
        chk("rst_addressed", int'(addressed), 0);
        chk("rst_nack", int'(nack_rcvd), 0);
        rst_n = 1'b1;
        wait_clks(20);

        // Write 0x88 then 0xFD
        do_start(); e_start++;
        write_byte(8'h88, acked);
        chk("w_addr_ack", int'(acked), 1);
        exp_rx.push_back(8'hFD); e_rxv++;
        write_byte(8'hFD, acked);
        chk("w_data_ack", int'(acked), 1);
        do_stop(); e_stop++;
        chk("w_rx_data_lit", int'(rx_data), 8'hFD);
        chk("w_one_rx_valid", cnt_rxv, 1);
        check_counts();

        // Read 0x89 returning A5 then 3C, ACK then NACK
        tx_plan.push_back(8'hA5); tx_plan.push_back(8'h3C);
        s0 = cnt_txreq;
        do_start(); e_start++;
        write_byte(8'h89, acked);
        chk("r_addr_ack", int'(acked), 1);
        read_byte(1'b1, d); e_txreq++;
        chk("r_byte0_lit", int'(d), 8'hA5);
        if (exp_tx.size() != 0) void'(exp_tx.pop_front());
        read_byte(1'b0, d); e_txreq++; e_nack++;
        chk("r_byte1_lit", int'(d), 8'h3C);
        if (exp_tx.size() != 0) void'(exp_tx.pop_front());
        do_stop(); e_stop++;
        chk("r_two_tx_req", cnt_txreq - s0, 2);
        chk("r_one_nack", cnt_nack, 1);
        check_counts();

        // Wrong address 0x45: silent target
        run_txn(7'h45, 1'b0, 1, 1'b1);

        // SDA glitch of 3 cycles on an idle bus
        s0 = cnt_start;
        ctrl_sda = 1'b0;
        wait_clks(3);
        ctrl_sda = 1'b1;
        wait_clks(20);
        chk("glitch_no_start", cnt_start - s0, 0);
        ctrl_sda = 1'b1;
        check_counts();

        // Write, repeated START, read, then STOP
        s0 = cnt_start;
        do_start(); e_start++;
        write_byte(8'h88, acked);
        chk("rs_w_ack", int'(acked), 1);
        exp_rx.push_back(8'h5A); e_rxv++;
        write_byte(8'h5A, acked);
        chk("rs_w_data_ack", int'(acked), 1);
        do_start(); e_start++;
        write_byte(8'h89, acked);
        chk("rs_r_ack", int'(acked), 1);
        chk("rs_addressed", int'(addressed), 1);
        read_byte(1'b0, d); e_txreq++; e_nack++;
        if (exp_tx.size() == 0) chk("rs_rd_missing", 1, 0);
        else chk("rs_rd_data", int'(d), int'(exp_tx.pop_front()));
        do_stop(); e_stop++;
        chk("rs_two_starts", cnt_start - s0, 2);
        check_counts();

        // Repeated START three bits into a write byte aborts it
        do_start(); e_start++;
        write_byte(8'h88, acked);
        chk("ab_addr_ack", int'(acked), 1);
        clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s);
        do_start(); e_start++;
        write_byte(8'h88, acked);
        chk("ab_addr2_ack", int'(acked), 1);
        exp_rx.push_back(8'h11); e_rxv++;
        write_byte(8'h11, acked);
        do_stop(); e_stop++;
        chk("ab_rx_data_lit", int'(rx_data), 8'h11);
        check_counts();

        // Reset while the target drives a 0 data bit
        tx_plan.push_back(8'h12);
        do_start(); e_start++;
        write_byte(8'h89, acked);
        e_txreq++;
        chk("rst_rd_ack", int'(acked), 1);
        wait_clks(30);
        chk("rst_rd_driving0", int'(sda_drive_low), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_drive", int'(sda_drive_low), 0);
        chk("async_rst_addressed", int'(addressed), 0);
        chk("async_rst_rx_data", int'(rx_data), 0);
        wait_clks(5);
        rst_n = 1'b1;
        exp_tx.delete();
        tx_plan.delete();
        quiet_chk = 1'b1;
        for (int i = 0; i < 9; i++) begin
            clock_bit(1'b1, s);
            chk("post_rst_idle", int'(s), 1);
        end
        do_stop(); e_stop++;
        quiet_chk = 1'b0;
        check_counts();

        // Randomised transactions
        for (int k = 0; k < 10; k++) begin
            logic [6:0] a;
            logic rw, st;
            int n;
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            st = (k == 9) || ($urandom_range(0, 2) != 0);
            run_txn(a, rw, n, st);
        end

        wait_clks(20);
        chk("rx_queue_drained", exp_rx.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
